// File: rtl/ifm_buf_pkg.sv
// Shared types and defaults for the banked IFM buffer.
`ifndef IFM_BUF_PKG_SV
`define IFM_BUF_PKG_SV

// Legal bank-count range for the banked IFM buffer.
`define IFM_BUF_NUM_BANKS_OK(n) (((n) >= 2) && ((n) <= 8))

package ifm_buf_pkg;

  localparam int unsigned IFM_DATA_WIDTH = 16;

  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_e;

endpackage

`endif

// File: rtl/ifm_bank_ram.sv
// One IFM bank: simple dual-port RAM with a 1-cycle synchronous read.
// The read register holds its value between reads and clears on reset/flush,
// so the top level can mux bank outputs without extra holding logic.
module ifm_bank_ram #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 4608,
  parameter int unsigned AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_q;

  // Storage write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port; holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (rd_en) begin
      r_q <= r_mem[rd_addr];
    end
  end

  assign rd_data = r_q;

endmodule

// File: rtl/ifm_bank_buffer.sv
// N-bank IFM buffer: round-robin bank fill, in-order bank drain with rewind.
module ifm_bank_buffer
  import ifm_buf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = IFM_DATA_WIDTH,
  parameter int unsigned DEPTH      = 4608,
  parameter int unsigned NUM_BANKS  = 2,
  parameter int unsigned AW         = $clog2(DEPTH),
  parameter int unsigned BW         = $clog2(NUM_BANKS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_last,
  output logic                  wr_ready,
  input  logic                  rd_en,
  input  logic                  rd_rewind,
  input  logic                  rd_release,
  output logic                  rd_avail,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_vld,
  output logic                  rd_last,
  output logic [BW-1:0]         wr_bank,
  output logic [BW-1:0]         rd_bank,
  output logic [BW:0]           full_cnt
);

  if (!(`IFM_BUF_NUM_BANKS_OK(NUM_BANKS))) begin : g_bad_num_banks
    $error("ifm_bank_buffer: NUM_BANKS must be in 2..8");
  end

  bank_state_e           r_state [NUM_BANKS];
  logic [AW:0]           r_cnt   [NUM_BANKS];
  logic [AW-1:0]         r_wp;
  logic [AW-1:0]         r_rp;
  logic [BW-1:0]         r_wr_bank;
  logic [BW-1:0]         r_rd_bank;
  logic [BW-1:0]         r_rd_sel;
  logic [BW:0]           r_full_cnt;
  logic                  r_rd_vld;
  logic                  r_rd_last;

  logic                  w_wr_ready;
  logic                  w_rd_avail;
  logic                  w_wr_acc;
  logic                  w_commit;
  logic                  w_rd_acc;
  logic                  w_rd_is_last;
  logic                  w_release;
  logic [AW:0]           w_rd_cnt;
  logic [DATA_WIDTH-1:0] w_ram_q [NUM_BANKS];

  // Round-robin successor of a bank index.
  function automatic logic [BW-1:0] f_next_bank(input logic [BW-1:0] b);
    return (b == BW'(NUM_BANKS - 1)) ? '0 : b + BW'(1);
  endfunction

  // Handshake decode; flush masks every strobe in its cycle.
  always_comb begin
    w_rd_cnt     = r_cnt[r_rd_bank];
    w_wr_ready   = (r_state[r_wr_bank] == BANK_EMPTY) &&
                   (r_full_cnt != (BW+1)'(NUM_BANKS));
    w_rd_avail   = (r_state[r_rd_bank] == BANK_FULL) && (r_full_cnt != '0);
    w_wr_acc     = wr_en && w_wr_ready && !clr;
    w_commit     = w_wr_acc && (wr_last || (r_wp == AW'(DEPTH - 1)));
    w_rd_acc     = rd_en && w_rd_avail && !rd_rewind && !clr &&
                   ({1'b0, r_rp} < w_rd_cnt);
    w_rd_is_last = (({1'b0, r_rp} + (AW+1)'(1)) == w_rd_cnt);
    w_release    = rd_release && w_rd_avail && !clr;
  end

  // Bank state, pointers, fill counts and read-side status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        r_state[b] <= BANK_EMPTY;
        r_cnt[b]   <= '0;
      end
      r_wp       <= '0;
      r_rp       <= '0;
      r_wr_bank  <= '0;
      r_rd_bank  <= '0;
      r_rd_sel   <= '0;
      r_full_cnt <= '0;
      r_rd_vld   <= 1'b0;
      r_rd_last  <= 1'b0;
    end else if (clr) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        r_state[b] <= BANK_EMPTY;
        r_cnt[b]   <= '0;
      end
      r_wp       <= '0;
      r_rp       <= '0;
      r_wr_bank  <= '0;
      r_rd_bank  <= '0;
      r_rd_sel   <= '0;
      r_full_cnt <= '0;
      r_rd_vld   <= 1'b0;
      r_rd_last  <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        if (w_commit) begin
          r_state[r_wr_bank] <= BANK_FULL;
          r_cnt[r_wr_bank]   <= {1'b0, r_wp} + (AW+1)'(1);
          r_wp               <= '0;
          r_wr_bank          <= f_next_bank(r_wr_bank);
        end else begin
          r_wp <= r_wp + AW'(1);
        end
      end

      r_rd_vld  <= w_rd_acc;
      r_rd_last <= w_rd_acc && w_rd_is_last;
      if (w_rd_acc) begin
        r_rd_sel <= r_rd_bank;
      end

      // Release outranks rewind/advance; a same-cycle read used the old bank.
      if (w_release) begin
        r_state[r_rd_bank] <= BANK_EMPTY;
        r_rp               <= '0;
        r_rd_bank          <= f_next_bank(r_rd_bank);
      end else if (rd_rewind) begin
        r_rp <= '0;
      end else if (w_rd_acc) begin
        r_rp <= r_rp + AW'(1);
      end

      // Commit and release always hit different banks, so they cancel.
      case ({w_commit, w_release})
        2'b10:   r_full_cnt <= r_full_cnt + (BW+1)'(1);
        2'b01:   r_full_cnt <= r_full_cnt - (BW+1)'(1);
        default: r_full_cnt <= r_full_cnt;
      endcase
    end
  end

  // One RAM per bank; only the active write/read bank sees a strobe.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    ifm_bank_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AW         (AW)
    ) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr),
      .wr_en   (w_wr_acc && (r_wr_bank == BW'(b))),
      .wr_addr (r_wp),
      .wr_data (wr_data),
      .rd_en   (w_rd_acc && (r_rd_bank == BW'(b))),
      .rd_addr (r_rp),
      .rd_data (w_ram_q[b])
    );
  end

  assign wr_ready    = w_wr_ready;
  assign rd_avail    = w_rd_avail;
  assign rd_data     = w_ram_q[r_rd_sel];
  assign rd_data_vld = r_rd_vld;
  assign rd_last     = r_rd_last;
  assign wr_bank     = r_wr_bank;
  assign rd_bank     = r_rd_bank;
  assign full_cnt    = r_full_cnt;

endmodule
